// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word type, the NOP bubble word, fetch FSM
// state encoding and a word-alignment helper.
package pipeline_pkg;

  typedef logic [31:0] word_t;

  // sll $0,$0,0 -- the canonical MIPS no-op used for bubbles.
  localparam word_t NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Clear the two byte-offset bits so a branch/jump target is word aligned.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Update priority per edge: rst > flush > stall > capture.
// A flush or reset loads a bubble (NOP_VALUE, PC+4 = 0, valid = 0).
// A stall holds every field.
module ifid_register
  import pipeline_pkg::*;
#(
  parameter word_t NOP_VALUE = NOP_WORD
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  stall,
  input  word_t instruction,
  input  word_t pc_plus4,
  output word_t ifid_instruction,
  output word_t ifid_pc_plus4,
  output logic  ifid_valid
);

  // Bubble on reset/flush, hold on stall, otherwise capture the fetched word.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ifid_instruction <= NOP_VALUE;
      ifid_pc_plus4    <= '0;
      ifid_valid       <= 1'b0;
    end else if (!stall) begin
      ifid_instruction <= instruction;
      ifid_pc_plus4    <= pc_plus4;
      ifid_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: program counter, combinational instruction-memory
// address, and the IF/ID register.
// Optional feature macro FETCH_PERF_CNT_EN adds FetchCount / StallCount
// performance counters and their output ports.
//
// Control semantics: Stall holds the PC and IF/ID; PCSrc redirects the PC to
// the word-aligned Target even while stalled; Flush turns IF/ID into a bubble
// and wins over Stall. All three are sampled only on the rising edge.
module instruction_fetch_stage
  import pipeline_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  Clk,
  input  logic  Rst,
  input  logic  Stall,
  input  logic  Flush,
  input  logic  PCSrc,
  input  word_t Target,
  output word_t Address,
  input  word_t Instruction,
  output word_t IFID_Instruction,
  output word_t IFID_PCPlus4,
  output logic  IFID_Valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output word_t FetchCount,
  output word_t StallCount
`endif
);

  word_t        pc;
  word_t        pc_plus4;
  fetch_state_e fsm_state;

  // Wraps modulo 2^32 by construction of the 32-bit sum.
  assign pc_plus4 = pc + 32'd4;

  // While booting the PC is RESET_PC anyway; the mux just makes the BOOT
  // address explicit without adding any path from the control inputs.
  assign Address = (fsm_state == BOOT) ? RESET_PC : pc;

  // Fetch control FSM: BOOT while in reset, RUN from the first edge after.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      fsm_state <= BOOT;
    end else begin
      fsm_state <= RUN;
    end
  end

  // Next-PC selection: Rst > PCSrc > Stall > sequential PC+4.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc <= RESET_PC;
    end else if (PCSrc) begin
      pc <= word_align(Target);
    end else if (!Stall) begin
      pc <= pc_plus4;
    end
  end

  ifid_register #(
    .NOP_VALUE(NOP_WORD)
  ) u_ifid (
    .clk             (Clk),
    .rst             (Rst),
    .flush           (Flush),
    .stall           (Stall),
    .instruction     (Instruction),
    .pc_plus4        (pc_plus4),
    .ifid_instruction(IFID_Instruction),
    .ifid_pc_plus4   (IFID_PCPlus4),
    .ifid_valid      (IFID_Valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic capture;

  // Mirrors the IF/ID capture branch (Rst is handled in the counter block).
  assign capture = !Flush && !Stall;

  // Performance counters: captures and non-flushed stall edges, wrapping.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (capture) begin
        FetchCount <= FetchCount + 32'd1;
      end
      if (Stall && !Flush) begin
        StallCount <= StallCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed walk through the fetch
// scenarios followed by randomized control traffic, all checked against a
// cycle-level behavioural model of the fetch stage.
module tb_instruction_fetch_stage;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Flush;
  logic        PCSrc;
  logic [31:0] Target;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  instruction_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Stall           (Stall),
    .Flush           (Flush),
    .PCSrc           (PCSrc),
    .Target          (Target),
    .Address         (Address),
    .Instruction     (Instruction),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4    (IFID_PCPlus4),
    .IFID_Valid      (IFID_Valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount      (FetchCount),
    .StallCount      (StallCount)
`endif
  );

  // Instruction memory with memory[i] = i*4: the word at byte address a is a.
  assign Instruction = Address;

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_stall_cnt;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model of one clock edge, written from the stage's rules.
  task automatic model_edge(input logic rst, input logic stall, input logic flush,
                            input logic pcsrc, input logic [31:0] target);
    logic [31:0] fetched;
    fetched = m_pc;  // memory[pc/4] == pc
    if (rst) begin
      m_pc = RESET_PC;
      m_inst = NOP; m_pc4 = 0; m_valid = 0;
      m_fetch_cnt = 0; m_stall_cnt = 0;
    end else begin
      if (flush) begin
        m_inst = NOP; m_pc4 = 0; m_valid = 0;
      end else if (!stall) begin
        m_inst = fetched; m_pc4 = m_pc + 4; m_valid = 1;
        m_fetch_cnt = m_fetch_cnt + 1;
      end
      if (stall && !flush) m_stall_cnt = m_stall_cnt + 1;
      if (pcsrc)       m_pc = target & 32'hFFFF_FFFC;
      else if (!stall) m_pc = m_pc + 4;
    end
    exp_q.push_back(m_inst);
  endtask

  // Drive one cycle, let the edge happen, then compare just after it.
  task automatic step(input logic rst, input logic stall, input logic flush,
                      input logic pcsrc, input logic [31:0] target);
    logic [31:0] exp_inst;
    Rst = rst; Stall = stall; Flush = flush; PCSrc = pcsrc; Target = target;
    model_edge(rst, stall, flush, pcsrc, target);
    @(posedge Clk);
    #1;
    exp_inst = exp_q.pop_front();
    check_eq("address", Address, m_pc);
    check_eq("ifid_instruction", IFID_Instruction, exp_inst);
    check_eq("ifid_pcplus4", IFID_PCPlus4, m_pc4);
    check_eq("ifid_valid", {31'd0, IFID_Valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    check_eq("fetch_count", FetchCount, m_fetch_cnt);
    check_eq("stall_count", StallCount, m_stall_cnt);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Rst = 1'b1; Stall = 1'b0; Flush = 1'b0; PCSrc = 1'b0; Target = '0;
    m_pc = RESET_PC; m_inst = NOP; m_pc4 = 0; m_valid = 0;
    m_fetch_cnt = 0; m_stall_cnt = 0;

    // Reset for two cycles.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_eq("reset_address", Address, RESET_PC);
    check_eq("reset_valid", {31'd0, IFID_Valid}, 32'd0);

    // Sequential fetch: 0 -> 4 -> 8 -> 12 -> 16.
    step(0, 0, 0, 0, 0);
    check_eq("boot_capture_inst", IFID_Instruction, 32'd0);
    check_eq("boot_capture_pc4", IFID_PCPlus4, 32'd4);
    check_eq("boot_capture_valid", {31'd0, IFID_Valid}, 32'd1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("seq_address16", Address, 32'd16);

    // Stall three cycles at 16.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    check_eq("stall_address", Address, 32'd16);
    check_eq("stall_hold_inst", IFID_Instruction, 32'd12);
    check_eq("stall_hold_pc4", IFID_PCPlus4, 32'd16);
    step(0, 0, 0, 0, 0);
    check_eq("resume_address", Address, 32'd20);
    step(0, 0, 0, 0, 0);

    // Taken branch at 24 with unaligned target.
    step(0, 0, 1, 1, 32'h0000_0043);
    check_eq("branch_address", Address, 32'h40);
    check_eq("branch_bubble_valid", {31'd0, IFID_Valid}, 32'd0);
    step(0, 0, 0, 0, 0);
    check_eq("branch_target_inst", IFID_Instruction, 32'h40);

    // Stall + Flush + PCSrc together: redirect still happens, bubble inserted.
    step(0, 1, 1, 1, 32'h0000_0080);
    check_eq("sfp_address", Address, 32'h80);
    check_eq("sfp_valid", {31'd0, IFID_Valid}, 32'd0);

    // Redirect without flush to 36, then reset during a stall.
    step(0, 0, 0, 1, 32'd36);
    check_eq("redirect36", Address, 32'd36);
    step(1, 1, 0, 0, 0);
    check_eq("rst_in_stall_address", Address, RESET_PC);
    check_eq("rst_in_stall_valid", {31'd0, IFID_Valid}, 32'd0);
    step(0, 0, 0, 0, 0);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0);
    check_eq("wrap_address", Address, 32'h0);
    check_eq("wrap_pc4", IFID_PCPlus4, 32'h0);
    check_eq("wrap_inst", IFID_Instruction, 32'hFFFF_FFFC);

    // Randomized control traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_stall, r_flush, r_pcsrc;
      logic [31:0] r_target;
      r_rst    = ($urandom_range(0, 59) == 0);
      r_stall  = ($urandom_range(0, 3) == 0);
      r_flush  = ($urandom_range(0, 5) == 0);
      r_pcsrc  = ($urandom_range(0, 5) == 0);
      r_target = $urandom;
      if ($urandom_range(0, 7) == 0) r_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      step(r_rst, r_stall, r_flush, r_pcsrc, r_target);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
